// File: rtl/rvfi_commit_serializer_if.sv
// -----------------------------------------------------------------------------
// rvfi_commit_serializer_if
//
// Purpose:
//   Bundles the two data-carrying sides of the RVFI commit serializer:
//     - the commit side, where the core presents up to NrCommitPorts retired
//       instruction records per cycle (no back-pressure possible), and
//     - the trace side, a valid/ready stream of one record per cycle.
//
// Signals (directions named from the serializer's point of view):
//   rvfi_valid_i  [NrCommitPorts]       per-port record valid
//   rvfi_rec_i    [NrCommitPorts*RecW]  records, port p at [p*RecW +: RecW]
//   out_valid_o                         head record available
//   out_rec_o     [RecW]                head record
//   out_ready_i                         sink accepts the head this cycle
//
// Modports:
//   slave  - the serializer itself (consumes commits, drives the stream)
//   master - the environment (core + trace writer) around it
// -----------------------------------------------------------------------------
interface rvfi_commit_serializer_if #(
  parameter int NrCommitPorts = 2,
  parameter int RecW          = 256
);

  logic [NrCommitPorts-1:0]      rvfi_valid_i;
  logic [NrCommitPorts*RecW-1:0] rvfi_rec_i;
  logic                          out_valid_o;
  logic [RecW-1:0]               out_rec_o;
  logic                          out_ready_i;

  modport slave (
    input  rvfi_valid_i,
    input  rvfi_rec_i,
    input  out_ready_i,
    output out_valid_o,
    output out_rec_o
  );

  modport master (
    output rvfi_valid_i,
    output rvfi_rec_i,
    output out_ready_i,
    input  out_valid_o,
    input  out_rec_o
  );

endinterface : rvfi_commit_serializer_if

// File: rtl/rvfi_commit_serializer.sv
// -----------------------------------------------------------------------------
// rvfi_commit_serializer
//
// Purpose:
//   Sits directly upstream of the RVFI trace writer. Each cycle it captures up
//   to NrCommitPorts retired-instruction records, compacts the valid ones in
//   ascending port order and appends them to a FIFO. The FIFO head is offered
//   one record per cycle on a valid/ready stream, oldest first.
//   The core can never be stalled, so when a cycle's group does not fit the
//   whole group is discarded (never a partial group, which would reorder the
//   trace), the sticky overflow flag is raised and the saturating drop
//   counter is advanced by the number of discarded records.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous reset, active-high
//   flush_i      synchronous flush: empties the FIFO, keeps overflow/drop state
//   bus_if       rvfi_commit_serializer_if.slave
//                  rvfi_valid_i / rvfi_rec_i : commit side
//                  out_valid_o / out_rec_o / out_ready_i : trace stream
//   level_o      current occupancy, 0..Depth
//   overflow_o   sticky: at least one group has been dropped
//   drop_cnt_o   number of dropped records, saturating at all-ones
//
// Timing:
//   A record written in cycle N is first visible on out_* in cycle N+1; there
//   is no fall-through path. The head is read straight from the register
//   array, so out_rec_o is stable for as long as out_valid_o waits for ready.
// -----------------------------------------------------------------------------
module rvfi_commit_serializer #(
  parameter int NrCommitPorts = 2,    // 1..4
  parameter int RecW          = 256,  // packed rvfi_instr_t width
  parameter int Depth         = 16,   // power of two, >= NrCommitPorts, >= 2
  parameter int CntW          = 16    // drop counter width
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  rvfi_commit_serializer_if.slave     bus_if,
  output logic [$clog2(Depth):0]      level_o,
  output logic                        overflow_o,
  output logic [CntW-1:0]             drop_cnt_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int LvlW = PtrW + 1;
  // Enough bits to hold a count of 0..NrCommitPorts valid records.
  localparam int CW   = $clog2(NrCommitPorts + 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [RecW-1:0] mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [LvlW-1:0] level_q,    level_d;
  logic            overflow_q, overflow_d;
  logic [CntW-1:0] drop_cnt_q, drop_cnt_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [CW-1:0]   grp_cnt;                 // popcount of rvfi_valid_i
  logic [CW-1:0]   grp_offs [NrCommitPorts]; // slot offset of each port's record
  logic [PtrW-1:0] wr_addr  [NrCommitPorts]; // FIFO slot of each port's record
  logic [RecW-1:0] port_rec [NrCommitPorts];
  logic            pop;
  logic            fits;
  logic            push_en;
  logic [LvlW:0]   free_slots;
  logic [CntW:0]   drop_sum;

  // Port p's record lands after all lower-numbered valid records, which is
  // exactly the running popcount of the lower ports. This is what closes the
  // gaps, e.g. a port-1-only group lands at wr_ptr.
  always_comb begin
    logic [CW-1:0] run;
    run = '0;
    for (int p = 0; p < NrCommitPorts; p++) begin
      grp_offs[p] = run;
      run         = run + CW'(bus_if.rvfi_valid_i[p]);
    end
    grp_cnt = run;
  end

  generate
    for (genvar gi = 0; gi < NrCommitPorts; gi++) begin : g_port
      assign port_rec[gi] = bus_if.rvfi_rec_i[gi*RecW +: RecW];
      // Pointer arithmetic wraps naturally because Depth is a power of two.
      assign wr_addr[gi]  = wr_ptr_q + PtrW'(grp_offs[gi]);
    end
  endgenerate

  assign pop = (level_q != '0) && bus_if.out_ready_i;

  // A pop in the same cycle frees its slot for this cycle's push, so a full
  // FIFO being drained can still take a single record.
  assign free_slots = (LvlW+1)'(Depth) - {1'b0, level_q} + (LvlW+1)'(pop);
  assign fits       = ((LvlW+1)'(grp_cnt) <= free_slots);

  // Flush wins over everything that would move the pointers this cycle.
  assign push_en  = !flush_i && fits && (grp_cnt != '0);

  assign drop_sum = {1'b0, drop_cnt_q} + (CntW+1)'(grp_cnt);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (flush_i) begin
      // Flush discards both the pending push and the pending pop. The drop
      // statistics survive so software can still see earlier losses.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end

      if (fits) begin
        wr_ptr_d = wr_ptr_q + PtrW'(grp_cnt);
        level_d  = level_q + LvlW'(grp_cnt) - LvlW'(pop);
      end else begin
        // The group is dropped as a whole; the pop still happens.
        level_d    = level_q - LvlW'(pop);
        overflow_d = 1'b1;
        drop_cnt_d = drop_sum[CntW] ? {CntW{1'b1}} : drop_sum[CntW-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Record storage
  // ---------------------------------------------------------------------------
  // The array carries no reset: its contents are only observable while
  // level_q says they are valid, and reset clears level_q.
  // Compacted addresses are distinct within a group, so the per-port writes
  // never collide.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NrCommitPorts; p++) begin
      if (push_en && bus_if.rvfi_valid_i[p]) begin
        mem_q[wr_addr[p]] <= port_rec[p];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus_if.out_valid_o = (level_q != '0);
  assign bus_if.out_rec_o   = mem_q[rd_ptr_q];
  assign level_o            = level_q;
  assign overflow_o         = overflow_q;
  assign drop_cnt_o         = drop_cnt_q;

endmodule : rvfi_commit_serializer

// File: tb/tb_rvfi_commit_serializer.sv
module tb_rvfi_commit_serializer;

  localparam int NP    = 2;
  localparam int RW    = 256;
  localparam int DEPTH = 16;
  localparam int CNTW  = 16;
  localparam int CMAX  = (1 << CNTW) - 1;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            flush_i;
  logic [4:0]      level_o;
  logic            overflow_o;
  logic [CNTW-1:0] drop_cnt_o;

  rvfi_commit_serializer_if #(.NrCommitPorts(NP), .RecW(RW)) bus ();

  rvfi_commit_serializer #(
    .NrCommitPorts(NP), .RecW(RW), .Depth(DEPTH), .CntW(CNTW)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .bus_if     (bus),
    .level_o    (level_o),
    .overflow_o (overflow_o),
    .drop_cnt_o (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: the FIFO is just an ordered queue of records.
  logic [RW-1:0] mq[$];
  bit            m_ovf;
  int            m_drop;
  int            wr_total;   // records accepted since last reset/flush
  int            total_cmp;
  int            bad_cmp;

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    total_cmp++;
    if (obs !== exp) begin
      bad_cmp++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] rand_rec();
    logic [RW-1:0] r;
    for (int i = 0; i < RW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive(input logic [NP-1:0] v, input bit rdy, input bit fl);
    bus.rvfi_valid_i = v;
    for (int p = 0; p < NP; p++) bus.rvfi_rec_i[p*RW +: RW] = rand_rec();
    bus.out_ready_i  = rdy;
    flush_i          = fl;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".valid"}, RW'(bus.out_valid_o), RW'(mq.size() != 0));
    check({tag, ".level"}, RW'(level_o), RW'(mq.size()));
    check({tag, ".ovf"},   RW'(overflow_o), RW'(m_ovf));
    check({tag, ".drop"},  RW'(drop_cnt_o), RW'(m_drop));
    if (mq.size() != 0) check({tag, ".rec"}, bus.out_rec_o, mq[0]);
  endtask

  // Advance one clock: update the model from the inputs the DUT sees at this
  // edge, then compare shortly after the edge.
  task automatic step(input string tag, input bit do_chk);
    int sz, n, free;
    bit pop;
    logic [RW-1:0] tmp;
    sz  = mq.size();
    pop = (sz != 0) && bus.out_ready_i;
    n   = $countones(bus.rvfi_valid_i);
    if (flush_i) begin
      mq.delete();
      wr_total = 0;
    end else begin
      free = DEPTH - sz + (pop ? 1 : 0);
      if (pop) tmp = mq.pop_front();
      if (n <= free) begin
        for (int p = 0; p < NP; p++)
          if (bus.rvfi_valid_i[p]) mq.push_back(bus.rvfi_rec_i[p*RW +: RW]);
        wr_total += n;
      end else begin
        m_ovf  = 1'b1;
        m_drop = (m_drop + n > CMAX) ? CMAX : m_drop + n;
      end
    end
    @(posedge clk_i);
    #1;
    if (do_chk) compare_all(tag);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf    = 1'b0;
    m_drop   = 0;
    wr_total = 0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    drive('0, 1'b0, 1'b0);
    model_reset();
    #2;
    compare_all("rst_async");
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    compare_all("rst_release");
  endtask

  initial begin
    logic [RW-1:0] rec_a, rec_b, rec_x;
    int guard;
    total_cmp = 0;
    bad_cmp   = 0;
    rst_i     = 1'b1;
    drive('0, 1'b0, 1'b0);
    model_reset();
    #3;
    do_reset();

    // 1. Two-record group drains one per cycle.
    drive(2'b11, 1'b1, 1'b0);
    rec_a = bus.rvfi_rec_i[0 +: RW];
    rec_b = bus.rvfi_rec_i[RW +: RW];
    step("t1_push", 1);
    check("t1_head_a", bus.out_rec_o, rec_a);
    drive(2'b00, 1'b1, 1'b0);
    step("t1_pop_a", 1);
    check("t1_head_b", bus.out_rec_o, rec_b);
    step("t1_pop_b", 1);
    check("t1_empty", RW'(level_o), RW'(0));

    // 2. Fill with sink stalled, then overflow drops a whole group.
    for (int i = 0; i < 8; i++) begin
      drive(2'b11, 1'b0, 1'b0);
      step("t2_fill", 1);
    end
    check("t2_full", RW'(level_o), RW'(16));
    rec_x = bus.out_rec_o;
    drive(2'b11, 1'b0, 1'b0);
    step("t2_drop", 1);
    check("t2_ovf", RW'(overflow_o), RW'(1));
    check("t2_cnt", RW'(drop_cnt_o), RW'(2));
    check("t2_head_kept", bus.out_rec_o, rec_x);

    // 3. Full FIFO with a simultaneous pop accepts a single record.
    drive(2'b01, 1'b1, 1'b0);
    step("t3_pushpop", 1);
    check("t3_level", RW'(level_o), RW'(16));
    check("t3_cnt", RW'(drop_cnt_o), RW'(2));

    // 4. Gap compaction across the wr_ptr wrap.
    guard = 0;
    while (mq.size() != 0 && guard < 40) begin
      drive(2'b00, 1'b1, 1'b0);
      step("t4_drain", 1);
      guard++;
    end
    guard = 0;
    while ((wr_total % DEPTH) != DEPTH-1 && guard < 40) begin
      drive(2'b01, 1'b1, 1'b0);
      step("t4_align", 1);
      guard++;
    end
    drive(2'b10, 1'b1, 1'b0);
    rec_a = bus.rvfi_rec_i[RW +: RW];
    step("t4_p1", 1);
    check("t4_first", bus.out_rec_o, rec_a);
    drive(2'b01, 1'b1, 1'b0);
    rec_b = bus.rvfi_rec_i[0 +: RW];
    step("t4_p0", 1);
    check("t4_second", bus.out_rec_o, rec_b);
    drive(2'b00, 1'b1, 1'b0);
    step("t4_idle", 1);

    // 5. Flush at level 5 ignores same-cycle push and pop.
    drive(2'b11, 1'b0, 1'b0); step("t5_fill", 1);
    drive(2'b11, 1'b0, 1'b0); step("t5_fill", 1);
    drive(2'b01, 1'b0, 1'b0); step("t5_fill", 1);
    check("t5_level5", RW'(level_o), RW'(5));
    drive(2'b11, 1'b1, 1'b1);
    step("t5_flush", 1);
    check("t5_lvl0", RW'(level_o), RW'(0));
    check("t5_nvalid", RW'(bus.out_valid_o), RW'(0));
    check("t5_ovf_kept", RW'(overflow_o), RW'(1));
    check("t5_cnt_kept", RW'(drop_cnt_o), RW'(2));

    // 6. Drop counter saturation.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(2'b11, 1'b0, 1'b0);
      step("t6_fill", 1);
    end
    for (int i = 0; i < 32767; i++) begin
      drive(2'b11, 1'b0, 1'b0);
      step("t6_bulk", 0);
    end
    check("t6_fffe", RW'(drop_cnt_o), RW'(16'hFFFE));
    drive(2'b11, 1'b0, 1'b0);
    step("t6_sat", 1);
    check("t6_ffff", RW'(drop_cnt_o), RW'(16'hFFFF));
    drive(2'b01, 1'b0, 1'b0);
    step("t6_hold", 1);
    check("t6_ffff_hold", RW'(drop_cnt_o), RW'(16'hFFFF));

    // Randomized traffic with stall phases and occasional flush.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int rpct;
      rpct = ((i / 200) % 2 == 0) ? 90 : 30;
      drive(NP'($urandom), ($urandom_range(0, 99) < rpct), ($urandom_range(0, 127) == 0));
      step("rnd", 1);
    end

    // Asynchronous reset mid-traffic.
    drive(2'b11, 1'b0, 1'b0);
    step("pre_rst", 1);
    drive(2'b11, 1'b0, 1'b0);
    step("pre_rst", 1);
    rst_i = 1'b1;
    model_reset();
    #2;
    check("arst_valid", RW'(bus.out_valid_o), RW'(0));
    check("arst_level", RW'(level_o), RW'(0));
    check("arst_ovf",   RW'(overflow_o), RW'(0));
    check("arst_drop",  RW'(drop_cnt_o), RW'(0));
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    drive(2'b00, 1'b1, 1'b0);
    step("post_rst", 1);

    $display("test done: total=%0d bad=%0d", total_cmp, bad_cmp);
    $finish;
  end

endmodule : tb_rvfi_commit_serializer
